// File: rtl/hub_arbiter_if.sv
// hub_arbiter_if: cog request bus and hub memory port around the slot arbiter
interface hub_arbiter_if #(parameter int NCOG = 8);
  localparam int SW = $clog2(NCOG);
  logic [NCOG-1:0] cog_req;
  logic [NCOG-1:0] cog_w;
  logic [4*NCOG-1:0] cog_wb;
  logic [14*NCOG-1:0] cog_a;
  logic [32*NCOG-1:0] cog_d;
  logic [NCOG-1:0] cog_ack;
  logic [31:0] cog_q;
  logic [SW-1:0] slot;
  logic mem_ena;
  logic mem_w;
  logic [3:0] mem_wb;
  logic [13:0] mem_a;
  logic [31:0] mem_d;
  logic [31:0] mem_q;
  modport master (
    output cog_req, cog_w, cog_wb, cog_a, cog_d, mem_q,
    input cog_ack, cog_q, slot, mem_ena, mem_w, mem_wb, mem_a, mem_d
  );
  modport slave (
    input cog_req, cog_w, cog_wb, cog_a, cog_d, mem_q,
    output cog_ack, cog_q, slot, mem_ena, mem_w, mem_wb, mem_a, mem_d
  );
endinterface

// File: rtl/hub_arbiter.sv
// hub_arbiter: round-robin slot scheduler sharing the hub memory among cogs
module hub_arbiter #(parameter int NCOG = 8) (
  input logic clk_cog,
  input logic nres,
  input logic ena_bus,
  hub_arbiter_if.slave bus
);
  localparam int SW = $clog2(NCOG);
  logic [SW-1:0] slot;
  logic [SW-1:0] owner;
  logic [SW-1:0] ack_owner;
  logic mem_vld;
  logic pending;
  logic [13:0] slot_a;
  assign slot_a = bus.cog_a[slot*14 +: 14];
  assign bus.slot = slot;
  assign bus.mem_ena = ena_bus & mem_vld;
  // sample stage: rotate the slot and latch the current owner's request fields
  always_ff @(posedge clk_cog or negedge nres)
    if (!nres) begin
      slot <= '0;
      owner <= '0;
      mem_vld <= 1'b0;
      bus.mem_w <= 1'b0;
      bus.mem_wb <= '0;
      bus.mem_a <= '0;
      bus.mem_d <= '0;
    end else if (ena_bus) begin
      slot <= slot + 1'b1;
      owner <= slot;
      mem_vld <= bus.cog_req[slot];
      bus.mem_w <= bus.cog_w[slot] & ~slot_a[13];
      bus.mem_wb <= bus.cog_wb[slot*4 +: 4];
      bus.mem_a <= slot_a;
      bus.mem_d <= bus.cog_d[slot*32 +: 32];
    end
  // access then completion: the ack pulse and read data follow one clock after the access edge
  always_ff @(posedge clk_cog or negedge nres)
    if (!nres) begin
      pending <= 1'b0;
      ack_owner <= '0;
      bus.cog_ack <= '0;
      bus.cog_q <= '0;
    end else begin
      pending <= ena_bus & mem_vld;
      ack_owner <= (ena_bus & mem_vld) ? owner : ack_owner;
      bus.cog_ack <= pending ? NCOG'(1) << ack_owner : '0;
      bus.cog_q <= pending ? bus.mem_q : bus.cog_q;
    end
endmodule

// File: doc/hub_arbiter.md
Name: hub_arbiter

Overview:
- Round-robin slot scheduler that shares the single-ported hub memory among NCOG cog requesters.
- Each ena_bus cycle the slot counter advances and the cog owning the current slot gets its pending request presented to hub memory on the next bus cycle.
- Read data and a completion pulse are returned to the owning cog.
- Sits between the cog array and the hub memory block. Drives that block's ena_bus/w/wb/a/d and consumes its q.

Parameters:
- NCOG, 8, number of requesters; power of two, 2..8; slot counter width is log2(NCOG).

Ports:
- clk_cog  in  1  hub/cog clock; single clock domain.
- nres  in  1  asynchronous active-low reset.
- ena_bus  in  1  bus-cycle enable from clock divider; all slot activity is qualified by it.
- cog_req  in  NCOG  per-cog request, held high until cog_ack.
- cog_w  in  NCOG  per-cog write (1) / read (0).
- cog_wb  in  4*NCOG  per-cog byte enables; cog i uses [4i+3:4i].
- cog_a  in  14*NCOG  per-cog long address.
- cog_d  in  32*NCOG  per-cog write data.
- cog_ack  out  NCOG  one-clk_cog completion pulse, one-hot.
- cog_q  out  32  read data, valid while any cog_ack bit is high.
- slot  out  log2(NCOG)  current slot owner (counter value).
- mem_ena  out  1  enable to hub memory = ena_bus & mem_vld (combinational AND).
- mem_w  out  1  registered write strobe.
- mem_wb  out  4  registered byte enables.
- mem_a  out  14  registered address.
- mem_d  out  32  registered write data.
- mem_q  in  32  hub memory read data (valid after the access edge).

Behaviour:
- Reset (nres low, async): slot=0, mem_vld=0, mem_w=0, mem_wb=0, mem_a=0, mem_d=0, cog_ack=0, cog_q=0, pending=0. Any in-flight access is dropped with no ack.
- Edge with ena_bus=1 (sample stage):
  - slot <= slot+1 mod NCOG.
  - mem_vld <= cog_req[slot].
  - owner <= slot.
  - mem_a/mem_d/mem_wb <= cog fields of the current slot.
  - mem_w <= cog_w[slot] & ~cog_a[slot][13]. Writes to ROM space are suppressed but still acked.
- Same ena_bus edge (access stage): if mem_vld=1, the memory performs the access; set pending <= 1 and ack_owner <= owner. Otherwise pending <= 0.
- Edge after access (any clk_cog edge, pending=1):
  - cog_ack[ack_owner] <= 1 for exactly one clk_cog cycle.
  - cog_q <= mem_q.
  - pending <= 0.
- Latency with ena_bus every 2nd cycle: sample at edge t, memory access at t+2, cog_ack/cog_q valid after t+3.
- Read-during-write: the memory returns old data, so cog_q on a write ack equals the pre-write contents (RAM region).
- Access while ena_bus=0: nothing advances; mem_* hold; pending ack still issues one cycle after the access edge.
- Strict rotation: no slot skipping or reallocation of idle slots. Worst-case wait is NCOG bus cycles.
- Request deasserted before its slot is sampled: no access, no ack.
- Request still high after ack: treated as new and served at the same cog's next slot (NCOG bus cycles later).
- Multiple cogs requesting: served in slot order; at most one ack bit per cycle.
- mem_vld low in a slot: mem_ena stays 0 and memory outputs are untouched.

Test Plan:
- Reset then idle:
  - Stimulus: nres low mid-access (pending=1).
  - Required: no cog_ack; all outputs 0.
  - After release with ena_bus toggling 1,0,1,0…, slot counts 0,1,…,7,0 on ena_bus edges.
- Single write then read:
  - Stimulus: cog 3 writes a=0x0010, d=0xDEADBEEF, wb=0xF at its slot; then reads 0x0010.
  - Required: write ack arrives 3 clk_cog after sample; read ack cog_q=0xDEADBEEF.
- Byte enables: wb=0x2, d=0x0000AB00 over 0xDEADBEEF → subsequent read returns 0xDEADABEF.
- ROM protect:
  - Stimulus: cog 0 writes a=0x2000.
  - Required: cog_ack[0] pulses; mem_w=0; a read of 0x2000 is unchanged.
- Contention: all 8 cogs request reads at once with slot=5 → acks in order 5,6,7,0,1,2,3,4, one per bus cycle, each with the correct address data.
- Stall: ena_bus held 0 for 10 cycles after a sample → no slot change; ack only after the next ena_bus edge +1 clk_cog.
